// File: rtl/img_arb_pkg.sv
// Shared types and default widths for the image-pipeline round-robin arbiter.
package img_arb_pkg;

  typedef enum logic [1:0] {
    MODE_DROP   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_LOCK   = 2'b11
  } arb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_LOCK  = 2'b10
  } arb_state_e;

  localparam int DEF_NUM_SLV   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_PV_W      = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int BEAT_CNT_W    = 4;

endpackage

// File: rtl/img_arb_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping past NUM_SLV-1.
module img_arb_rr_pick
  import img_arb_pkg::*;
#(
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SRC_W   = $clog2(DEF_NUM_SLV)
) (
  input  logic [NUM_SLV-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SLV-1:0] onehot,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < NUM_SLV; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_SLV) j = j - NUM_SLV;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = j[SRC_W-1:0];
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/img_arb_rr.sv
// img_arb_rr: N-slave round-robin arbiter merging pixel-word streams into one write FIFO.
// Define ARB_PERF_CNT_EN to add per-slave saturating accepted-beat counters (perf_cnt/perf_clr).
module img_arb_rr
  import img_arb_pkg::*;
#(
  parameter int NUM_SLV   = DEF_NUM_SLV,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PV_W      = DEF_PV_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int SRC_W    = $clog2(NUM_SLV)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SLV-1:0]        slv_data_valid,
  input  logic [2*NUM_SLV-1:0]      slv_mode,
  input  logic [PV_W*NUM_SLV-1:0]   slv_proc_valid,
  input  logic [DATA_W*NUM_SLV-1:0] slv_data,
  output logic [NUM_SLV-1:0]        slv_ready,
  input  logic                      fifo_full,
  input  logic                      mstr_cmplt,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [PV_W-1:0]           fifo_wr_pv,
  output logic [SRC_W-1:0]          fifo_wr_src,
  output logic                      arb_busy
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic                      perf_clr,
  output logic [16*NUM_SLV-1:0]     perf_cnt
`endif
);

  localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  arb_mode_e             gmode_q, gmode_d;
  logic [SRC_W-1:0]      grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W-1:0]     fifo_wr_data_q, fifo_wr_data_d;
  logic [PV_W-1:0]       fifo_wr_pv_q, fifo_wr_pv_d;
  logic [SRC_W-1:0]      fifo_wr_src_q, fifo_wr_src_d;

  logic [NUM_SLV-1:0]    cand, pick_onehot;
  logic [SRC_W-1:0]      pick_idx, grant_next;
  logic                  pick_any, accept, rel_grant;
  logic [1:0]            pick_mode_raw;

  always_comb begin
    cand          = '0;
    pick_mode_raw = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      cand[i] = slv_data_valid[i] && (slv_mode[2*i +: 2] != MODE_DROP);
      if (pick_onehot[i]) pick_mode_raw = slv_mode[2*i +: 2];
    end
  end

  img_arb_rr_pick #(
    .NUM_SLV (NUM_SLV),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req    (cand),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Drop-mode slaves are drained while idle so a stray beat never stalls its source.
  always_comb begin
    slv_ready = '0;
    if (state_q == ST_IDLE) begin
      for (int i = 0; i < NUM_SLV; i++)
        slv_ready[i] = slv_data_valid[i] && (slv_mode[2*i +: 2] == MODE_DROP);
    end else if (!fifo_full) begin
      slv_ready[grant_q] = 1'b1;
    end
  end

  assign accept     = (state_q != ST_IDLE) && slv_data_valid[grant_q] && !fifo_full;
  assign grant_next = (grant_q == SRC_W'(NUM_SLV - 1)) ? '0 : grant_q + SRC_W'(1);

  always_comb begin
    state_d    = state_q;
    gmode_d    = gmode_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rel_grant  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          gmode_d    = arb_mode_e'(pick_mode_raw);
          beat_cnt_d = '0;
          state_d    = (arb_mode_e'(pick_mode_raw) == MODE_LOCK) ? ST_LOCK : ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (gmode_q == MODE_BURST) begin
          if (accept) begin
            if (beat_cnt_q == BURST_LAST) rel_grant = 1'b1;
            else                          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end else if (!slv_data_valid[grant_q]) begin
            rel_grant = 1'b1;
          end
        end else if (accept) begin
          rel_grant = 1'b1;
        end
      end
      ST_LOCK: begin
        if (mstr_cmplt) rel_grant = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rel_grant) begin
      state_d    = ST_IDLE;
      rr_ptr_d   = grant_next;
      beat_cnt_d = '0;
    end
  end

  always_comb begin
    fifo_wr_en_d   = accept;
    fifo_wr_data_d = fifo_wr_data_q;
    fifo_wr_pv_d   = fifo_wr_pv_q;
    fifo_wr_src_d  = fifo_wr_src_q;
    if (accept) begin
      fifo_wr_data_d = slv_data[grant_q*DATA_W +: DATA_W];
      fifo_wr_pv_d   = slv_proc_valid[grant_q*PV_W +: PV_W];
      fifo_wr_src_d  = grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      gmode_q        <= MODE_DROP;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      fifo_wr_pv_q   <= '0;
      fifo_wr_src_q  <= '0;
    end else begin
      state_q        <= state_d;
      gmode_q        <= gmode_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      fifo_wr_pv_q   <= fifo_wr_pv_d;
      fifo_wr_src_q  <= fifo_wr_src_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign fifo_wr_pv   = fifo_wr_pv_q;
  assign fifo_wr_src  = fifo_wr_src_q;
  assign arb_busy     = (state_q != ST_IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [NUM_SLV-1:0][15:0] perf_cnt_q, perf_cnt_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (perf_clr)
        perf_cnt_d[i] = '0;
      else if (accept && (grant_q == SRC_W'(i)) && (perf_cnt_q[i] != 16'hFFFF))
        perf_cnt_d[i] = perf_cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_img_arb_rr.sv
// Directed bench for img_arb_rr: stimulus pushes expected writes into a scoreboard
// queue that an independent negedge monitor drains; also covers ARB_PERF_CNT_EN when defined.
module tb_img_arb_rr;

  localparam int NUM_SLV = 4;
  localparam int DATA_W  = 32;
  localparam int PV_W    = 8;
  localparam int SRC_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PV_W-1:0]   pv;
    logic [SRC_W-1:0]  src;
  } exp_t;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SLV-1:0]        slv_data_valid;
  logic [2*NUM_SLV-1:0]      slv_mode;
  logic [PV_W*NUM_SLV-1:0]   slv_proc_valid;
  logic [DATA_W*NUM_SLV-1:0] slv_data;
  logic [NUM_SLV-1:0]        slv_ready;
  logic                      fifo_full;
  logic                      mstr_cmplt;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic [PV_W-1:0]           fifo_wr_pv;
  logic [SRC_W-1:0]          fifo_wr_src;
  logic                      arb_busy;
`ifdef ARB_PERF_CNT_EN
  logic                      perf_clr;
  logic [16*NUM_SLV-1:0]     perf_cnt;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   writes_seen = 0;

  img_arb_rr dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .slv_data_valid (slv_data_valid),
    .slv_mode       (slv_mode),
    .slv_proc_valid (slv_proc_valid),
    .slv_data       (slv_data),
    .slv_ready      (slv_ready),
    .fifo_full      (fifo_full),
    .mstr_cmplt     (mstr_cmplt),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_wr_pv     (fifo_wr_pv),
    .fifo_wr_src    (fifo_wr_src),
    .arb_busy       (arb_busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_clr       (perf_clr),
    .perf_cnt       (perf_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every write seen on a negedge is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fifo_wr_en) begin
        writes_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write got data=%h pv=%h src=%0d required=no write",
                   fifo_wr_data, fifo_wr_pv, fifo_wr_src);
        end else begin
          e = sb.pop_front();
          if (fifo_wr_data !== e.data || fifo_wr_pv !== e.pv || fifo_wr_src !== e.src) begin
            errors++;
            $display("[TB] FAIL wr_beat got data=%h pv=%h src=%0d required data=%h pv=%h src=%0d",
                     fifo_wr_data, fifo_wr_pv, fifo_wr_src, e.data, e.pv, e.src);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [1:0] m,
                               input logic [DATA_W-1:0] d, input logic [PV_W-1:0] pv);
    slv_data_valid[idx]             = v;
    slv_mode[2*idx +: 2]            = m;
    slv_data[DATA_W*idx +: DATA_W]  = d;
    slv_proc_valid[PV_W*idx +: PV_W] = pv;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [DATA_W-1:0] d, input logic [PV_W-1:0] pv,
                         input logic [SRC_W-1:0] s);
    exp_t e;
    e.data = d;
    e.pv   = pv;
    e.src  = s;
    sb.push_back(e);
  endtask

  task automatic applyReset();
    rst_n          = 1'b0;
    slv_data_valid = '0;
    slv_mode       = '0;
    slv_proc_valid = '0;
    slv_data       = '0;
    fifo_full      = 1'b0;
    mstr_cmplt     = 1'b0;
`ifdef ARB_PERF_CNT_EN
    perf_clr       = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    $display("[TB] start");

    // Reset state
    applyReset();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_wr_en", fifo_wr_en, 0);
    checkOutput("rst_wr_data", fifo_wr_data, 0);
    checkOutput("rst_wr_pv", fifo_wr_pv, 0);
    checkOutput("rst_wr_src", fifo_wr_src, 0);
    checkOutput("rst_busy", arb_busy, 0);
    checkOutput("rst_ready", slv_ready, 0);
    rst_n = 1'b1;
    tick();

    // 1: single beat in burst mode, released on valid drop
    applyStimulus(0, 1'b1, 2'b10, 32'h2DAAD83D, 8'hFF);
    pushExp(32'h2DAAD83D, 8'hFF, 2'd0);
    #1;
    checkOutput("t1_ready_idle", slv_ready, 0);
    tick();
    checkOutput("t1_ready_grant", slv_ready, 4'b0001);
    checkOutput("t1_busy", arb_busy, 1);
    tick();
    checkOutput("t1_wr_en_latency", fifo_wr_en, 1);
    applyStimulus(0, 1'b0, 2'b10, 32'h0, 8'h00);
    tick();
    checkOutput("t1_release", arb_busy, 0);

    // 2: burst capped at 4 beats, then slv1 wins after the idle gap
    applyReset();
    applyStimulus(0, 1'b1, 2'b10, 32'hF9B550E1, 8'h0F);
    applyStimulus(1, 1'b1, 2'b01, 32'hBBBB0001, 8'hF0);
    pushExp(32'hF9B550E1, 8'h0F, 2'd0);
    pushExp(32'hA87EAF30, 8'h0F, 2'd0);
    pushExp(32'h8F57C788, 8'h0F, 2'd0);
    pushExp(32'h11111111, 8'h0F, 2'd0);
    pushExp(32'hBBBB0001, 8'hF0, 2'd1);
    tick();
    checkOutput("t2_ready_slv0", slv_ready, 4'b0001);
    tick();
    applyStimulus(0, 1'b1, 2'b10, 32'hA87EAF30, 8'h0F);
    tick();
    applyStimulus(0, 1'b1, 2'b10, 32'h8F57C788, 8'h0F);
    tick();
    applyStimulus(0, 1'b1, 2'b10, 32'h11111111, 8'h0F);
    tick();
    applyStimulus(0, 1'b1, 2'b10, 32'h22222222, 8'h0F);
    #1;
    checkOutput("t2_gap_busy", arb_busy, 0);
    checkOutput("t2_gap_ready", slv_ready, 0);
    tick();
    checkOutput("t2_next_slv1", slv_ready, 4'b0010);
    applyStimulus(0, 1'b0, 2'b10, 32'h0, 8'h00);
    tick();
    applyStimulus(1, 1'b0, 2'b01, 32'h0, 8'h00);
    tick();
    checkOutput("t2_idle_after", arb_busy, 0);

    // 3: round-robin over four single-mode slaves
    applyReset();
    for (int i = 0; i < NUM_SLV; i++)
      applyStimulus(i, 1'b1, 2'b01, 32'hC0DE0000 + i, 8'h01 << i);
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NUM_SLV;
      pushExp(32'hC0DE0000 + k, 8'h01 << g, SRC_W'(g));
      tick();
      checkOutput($sformatf("t3_rr_grant%0d", k), slv_ready, 4'b0001 << g);
      tick();
      if (k < 4) applyStimulus(g, 1'b1, 2'b01, 32'hC0DE0000 + k + 4, 8'h01 << g);
      else       slv_data_valid = '0;
    end
    tick();
    checkOutput("t3_idle_after", arb_busy, 0);

    // 4: backpressure for three cycles mid-burst
    applyReset();
    w0 = writes_seen;
    for (int i = 0; i < 4; i++) pushExp(32'hB0000000 + i, 8'h3C, 2'd0);
    applyStimulus(0, 1'b1, 2'b10, 32'hB0000000, 8'h3C);
    tick();
    tick();
    fifo_full = 1'b1;
    applyStimulus(0, 1'b1, 2'b10, 32'hB0000001, 8'h3C);
    #1;
    checkOutput("t4_full_ready", slv_ready, 0);
    tick();
    tick();
    checkOutput("t4_no_wr_a", fifo_wr_en, 0);
    checkOutput("t4_grant_held", arb_busy, 1);
    tick();
    checkOutput("t4_no_wr_b", fifo_wr_en, 0);
    fifo_full = 1'b0;
    #1;
    checkOutput("t4_resume_ready", slv_ready, 4'b0001);
    tick();
    applyStimulus(0, 1'b1, 2'b10, 32'hB0000002, 8'h3C);
    tick();
    applyStimulus(0, 1'b1, 2'b10, 32'hB0000003, 8'h3C);
    tick();
    applyStimulus(0, 1'b0, 2'b10, 32'h0, 8'h00);
    tick();
    tick();
    checkOutput("t4_total_writes", writes_seen - w0, 4);
    checkOutput("t4_idle_after", arb_busy, 0);

    // 5: drop-mode beat discarded; lock held through valid gaps until mstr_cmplt
    applyReset();
    applyStimulus(1, 1'b1, 2'b00, 32'hDEADBEEF, 8'h11);
    applyStimulus(2, 1'b1, 2'b11, 32'h10C40000, 8'hAA);
    #1;
    checkOutput("t5_drop_ready", slv_ready, 4'b0010);
    tick();
    applyStimulus(1, 1'b0, 2'b00, 32'h0, 8'h00);
    applyStimulus(0, 1'b1, 2'b01, 32'h5A5A0000, 8'h55);
    applyStimulus(2, 1'b1, 2'b01, 32'h10C40000, 8'hAA);
    pushExp(32'h10C40000, 8'hAA, 2'd2);
    #1;
    checkOutput("t5_lock_ready", slv_ready, 4'b0100);
    tick();
    applyStimulus(2, 1'b0, 2'b01, 32'h0, 8'hAA);
    checkOutput("t5_lock_hold", arb_busy, 1);
    tick();
    checkOutput("t5_lock_valid_low", slv_ready, 4'b0100);
    applyStimulus(2, 1'b1, 2'b01, 32'h10C40001, 8'hAA);
    pushExp(32'h10C40001, 8'hAA, 2'd2);
    tick();
    applyStimulus(2, 1'b0, 2'b01, 32'h0, 8'hAA);
    tick();
    checkOutput("t5_lock_still", arb_busy, 1);
    applyStimulus(2, 1'b1, 2'b01, 32'h10C40002, 8'hAA);
    pushExp(32'h10C40002, 8'hAA, 2'd2);
    mstr_cmplt = 1'b1;
    tick();
    mstr_cmplt = 1'b0;
    applyStimulus(2, 1'b0, 2'b01, 32'h0, 8'h00);
    #1;
    checkOutput("t5_cmplt_release", arb_busy, 0);
    pushExp(32'h5A5A0000, 8'h55, 2'd0);
    tick();
    checkOutput("t5_next_slv0", slv_ready, 4'b0001);
    tick();
    applyStimulus(0, 1'b0, 2'b01, 32'h0, 8'h00);
    tick();
    checkOutput("t5_idle_after", arb_busy, 0);

    // 6: asynchronous reset mid-burst, pointer restarts at 0
    applyReset();
    applyStimulus(1, 1'b1, 2'b01, 32'hE1E1E1E1, 8'hC3);
    applyStimulus(3, 1'b1, 2'b10, 32'hE3E3E3E3, 8'hC3);
    pushExp(32'hE1E1E1E1, 8'hC3, 2'd1);
    tick();
    checkOutput("t6_first_slv1", slv_ready, 4'b0010);
    tick();
    tick();
    checkOutput("t6_ptr_advanced", slv_ready, 4'b1000);
    tick();
`ifdef ARB_PERF_CNT_EN
    checkOutput("t6_perf_slv1", perf_cnt[16 +: 16], 1);
    checkOutput("t6_perf_slv3", perf_cnt[48 +: 16], 1);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wr_en", fifo_wr_en, 0);
    checkOutput("t6_rst_wr_data", fifo_wr_data, 0);
    checkOutput("t6_rst_wr_pv", fifo_wr_pv, 0);
    checkOutput("t6_rst_wr_src", fifo_wr_src, 0);
    checkOutput("t6_rst_busy", arb_busy, 0);
    checkOutput("t6_rst_ready", slv_ready, 0);
`ifdef ARB_PERF_CNT_EN
    checkOutput("t6_rst_perf", perf_cnt, 0);
`endif
    #1;
    rst_n = 1'b1;
    pushExp(32'hE1E1E1E1, 8'hC3, 2'd1);
    tick();
    checkOutput("t6_ptr_restart", slv_ready, 4'b0010);
    applyStimulus(3, 1'b0, 2'b10, 32'h0, 8'h00);
    tick();
    applyStimulus(1, 1'b0, 2'b01, 32'h0, 8'h00);
`ifdef ARB_PERF_CNT_EN
    checkOutput("t6_perf_after", perf_cnt[16 +: 16], 1);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkOutput("t6_perf_clr", perf_cnt, 0);
`endif
    tick();
    tick();
    checkOutput("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
